tcp_tx_ptr_store: RTL and testbench
===================================

Name: tcp_tx_ptr_store

Overview:
- Per-flow TX payload-buffer pointer store; sits directly downstream of the TX pointer NoC interface.
- Serves that interface's tail-pointer write, tail-pointer read and head-pointer read request/response channels.
- Also accepts head-pointer advances from the TCP engine's ACK path and flow-init writes from flow setup.
- Holds one {tail, head} pair per flow, each PTR_W+1 bits; the MSB is the wrap bit.

Parameters:
- FLOW_ID_W, 3, flow index width; depth = 2**FLOW_ID_W.
- PTR_W, 14, log2 of payload buffer bytes per flow; stored pointers are PTR_W+1 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- app_tail_ptr_tx_wr_req_val  in  1  tail write valid.
- app_tail_ptr_tx_wr_req_flowid  in  FLOW_ID_W  flow.
- app_tail_ptr_tx_wr_req_data  in  PTR_W+1  new tail.
- tail_ptr_app_tx_wr_req_rdy  out  1  tail write ready.
- app_tail_ptr_tx_rd_req_val  in  1  tail read valid.
- app_tail_ptr_tx_rd_req_flowid  in  FLOW_ID_W  flow.
- tail_ptr_app_tx_rd_req_rdy  out  1  tail read ready.
- tail_ptr_app_tx_rd_resp_val  out  1  tail response valid.
- tail_ptr_app_tx_rd_resp_flowid  out  FLOW_ID_W  echoed flow.
- tail_ptr_app_tx_rd_resp_data  out  PTR_W+1  tail value.
- app_tail_ptr_tx_rd_resp_rdy  in  1  tail response ready.
- app_head_ptr_tx_rd_req_val  in  1  head read valid.
- app_head_ptr_tx_rd_req_flowid  in  FLOW_ID_W  flow.
- head_ptr_app_tx_rd_req_rdy  out  1  head read ready.
- head_ptr_app_tx_rd_resp_val  out  1  head response valid.
- head_ptr_app_tx_rd_resp_flowid  out  FLOW_ID_W  echoed flow.
- head_ptr_app_tx_rd_resp_data  out  PTR_W+1  head value.
- app_head_ptr_tx_rd_resp_rdy  in  1  head response ready.
- eng_head_ptr_wr_req_val  in  1  ACK-path head advance valid.
- eng_head_ptr_wr_req_flowid  in  FLOW_ID_W  flow.
- eng_head_ptr_wr_req_data  in  PTR_W+1  new head.
- head_ptr_eng_wr_req_rdy  out  1  head advance ready.
- init_ptr_wr_req_val  in  1  flow init valid.
- init_ptr_wr_req_flowid  in  FLOW_ID_W  flow.
- init_ptr_wr_req_data  in  PTR_W+1  initial value written to both head and tail.
- tail_ovf_err  out  1  sticky error flag.

Behaviour:
- Storage is flop arrays head_mem and tail_mem. rst_n low clears all entries, both resp_val outputs, resp flowid/data and tail_ovf_err to 0, asynchronously.
- Write priority: init > tail write / head advance.
  - head_ptr_eng_wr_req_rdy = !init_ptr_wr_req_val.
  - tail_ptr_app_tx_wr_req_rdy = !init_ptr_wr_req_val.
  - Init is always accepted and writes head_mem and tail_mem at the next edge.
- A tail write and a head advance to the same flow in the same cycle both commit; they touch different arrays.
- Tail overflow check: occ = (wr_data - head_mem[flow]) mod 2**(PTR_W+1).
  - If occ > 2**PTR_W, the write is handshaken but dropped, and tail_ovf_err is set.
  - tail_ovf_err stays set until reset.
  - The check uses head_mem as it is at the start of the cycle; a same-cycle head advance is not considered.
- Each read port is a one-entry output register. req_rdy = !resp_val || resp_rdy, so full throughput is one read per cycle per port.
- Read latency is exactly 1 cycle: a request accepted at edge N gives resp_val high after edge N.
- resp_val clears on resp handshake unless a new request is accepted in the same cycle.
- Write-first bypass: a read accepted in the same cycle as a committing write to the same flow and array returns the new value.
  - This includes init writes.
  - A dropped (overflowed) tail write is not bypassed.
- While resp_val && !resp_rdy, resp data and flowid hold stable even if the array entry changes.
- Pointer values are stored verbatim; no wrap arithmetic is applied except in the overflow check.
- Reset asserted mid-operation drops outstanding responses; no handshake completes in that cycle.

Decomposition:
- Shared package tcp_tx_ptr_pkg holds:
  - FLOW_ID_W and PTR_W defaults;
  - typedef ptr_t of PTR_W+1 bits;
  - typedef ptr_rd_resp_t {flowid, data}.
- Sub-module tcp_tx_ptr_rd_port: one-entry read response register with handshake and bypass select. It is instantiated twice, once for tail and once for head.

Test Plan:
- Reset, then tail read flow 2 -> resp_val rises 1 cycle later with flowid=2, data=0. Head read gives the same.
- Init flow 5 with 0x100, then tail read and head read of flow 5 -> both return 0x100.
- Tail write flow 5 with 0x2100 (occ 0x2000 ≤ 0x4000), tail read flow 5 issued in the same cycle -> read returns 0x2100 via bypass.
- Tail write flow 5 with 0x4101 (occ 0x4001) -> accepted, tail_ovf_err=1, a later tail read still returns 0x2100.
- Hold app_head_ptr_tx_rd_resp_rdy=0 with resp valid, then send a head advance on the same flow -> head_ptr_app_tx_rd_req_rdy=0 and resp data is unchanged. Raise resp_rdy -> back-to-back reads return one per cycle.
- Init flow 1 and engine head advance flow 1 in the same cycle -> head_ptr_eng_wr_req_rdy=0. The advance is accepted the next cycle and a head read returns the advanced value.

Source files
------------

// File: rtl/tcp_tx_ptr_pkg.sv
// Shared types and default widths for the per-flow TX pointer store.
package tcp_tx_ptr_pkg;

   localparam int DEF_FLOW_ID_W = 3;
   localparam int DEF_PTR_W     = 14;

   typedef logic [DEF_PTR_W:0] ptr_t;

   typedef struct packed {
      logic [DEF_FLOW_ID_W-1:0] flowid;
      ptr_t                     data;
   } ptr_rd_resp_t;

endpackage

// File: rtl/tcp_tx_ptr_rd_port.sv
// One-entry read response register with valid/ready handshake and bypass select.
module tcp_tx_ptr_rd_port
   import tcp_tx_ptr_pkg::*;
#(
   parameter int FLOW_ID_W = DEF_FLOW_ID_W,
   parameter int PTR_W     = DEF_PTR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_val,
   input  logic [FLOW_ID_W-1:0] req_flowid,
   output logic                 req_rdy,
   input  logic                 byp_val,
   input  logic [PTR_W:0]       byp_data,
   input  logic [PTR_W:0]       mem_data,
   output logic                 resp_val,
   output logic [FLOW_ID_W-1:0] resp_flowid,
   output logic [PTR_W:0]       resp_data,
   input  logic                 resp_rdy
);

   logic           acc;
   logic [PTR_W:0] sel;

   assign req_rdy = !resp_val || resp_rdy;
   assign acc     = req_val && req_rdy;
   assign sel     = byp_val ? byp_data : mem_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_val    <= 1'b0;
         resp_flowid <= '0;
         resp_data   <= '0;
      end else if (acc) begin
         resp_val    <= 1'b1;
         resp_flowid <= req_flowid;
         resp_data   <= sel;
      end else if (resp_rdy) begin
         resp_val    <= 1'b0;
      end
   end

endmodule

// File: rtl/tcp_tx_ptr_store.sv
// Per-flow {tail, head} TX payload pointer store with tail overflow guard.
module tcp_tx_ptr_store
   import tcp_tx_ptr_pkg::*;
#(
   parameter int FLOW_ID_W = DEF_FLOW_ID_W,
   parameter int PTR_W     = DEF_PTR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 app_tail_ptr_tx_wr_req_val,
   input  logic [FLOW_ID_W-1:0] app_tail_ptr_tx_wr_req_flowid,
   input  logic [PTR_W:0]       app_tail_ptr_tx_wr_req_data,
   output logic                 tail_ptr_app_tx_wr_req_rdy,
   input  logic                 app_tail_ptr_tx_rd_req_val,
   input  logic [FLOW_ID_W-1:0] app_tail_ptr_tx_rd_req_flowid,
   output logic                 tail_ptr_app_tx_rd_req_rdy,
   output logic                 tail_ptr_app_tx_rd_resp_val,
   output logic [FLOW_ID_W-1:0] tail_ptr_app_tx_rd_resp_flowid,
   output logic [PTR_W:0]       tail_ptr_app_tx_rd_resp_data,
   input  logic                 app_tail_ptr_tx_rd_resp_rdy,
   input  logic                 app_head_ptr_tx_rd_req_val,
   input  logic [FLOW_ID_W-1:0] app_head_ptr_tx_rd_req_flowid,
   output logic                 head_ptr_app_tx_rd_req_rdy,
   output logic                 head_ptr_app_tx_rd_resp_val,
   output logic [FLOW_ID_W-1:0] head_ptr_app_tx_rd_resp_flowid,
   output logic [PTR_W:0]       head_ptr_app_tx_rd_resp_data,
   input  logic                 app_head_ptr_tx_rd_resp_rdy,
   input  logic                 eng_head_ptr_wr_req_val,
   input  logic [FLOW_ID_W-1:0] eng_head_ptr_wr_req_flowid,
   input  logic [PTR_W:0]       eng_head_ptr_wr_req_data,
   output logic                 head_ptr_eng_wr_req_rdy,
   input  logic                 init_ptr_wr_req_val,
   input  logic [FLOW_ID_W-1:0] init_ptr_wr_req_flowid,
   input  logic [PTR_W:0]       init_ptr_wr_req_data,
   output logic                 tail_ovf_err
);

   localparam int DEPTH = 2**FLOW_ID_W;
   localparam logic [PTR_W:0] OCC_MAX = {1'b1, {PTR_W{1'b0}}};

   logic [PTR_W:0] head_mem [DEPTH];
   logic [PTR_W:0] tail_mem [DEPTH];

   logic           tail_acc;
   logic           tail_ovf;
   logic           tail_we;
   logic           head_we;
   logic [PTR_W:0] occ;

   logic           t_init_hit;
   logic           t_byp_val;
   logic [PTR_W:0] t_byp_data;
   logic           h_init_hit;
   logic           h_byp_val;
   logic [PTR_W:0] h_byp_data;

   assign tail_ptr_app_tx_wr_req_rdy = !init_ptr_wr_req_val;
   assign head_ptr_eng_wr_req_rdy    = !init_ptr_wr_req_val;

   // Occupancy is checked against the head as stored, ignoring same-cycle advances
   assign occ      = app_tail_ptr_tx_wr_req_data
                   - head_mem[app_tail_ptr_tx_wr_req_flowid];
   assign tail_ovf = occ > OCC_MAX;
   assign tail_acc = app_tail_ptr_tx_wr_req_val && tail_ptr_app_tx_wr_req_rdy;
   assign tail_we  = tail_acc && !tail_ovf;
   assign head_we  = eng_head_ptr_wr_req_val && head_ptr_eng_wr_req_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            head_mem[i] <= '0;
            tail_mem[i] <= '0;
         end
         tail_ovf_err <= 1'b0;
      end else begin
         if (init_ptr_wr_req_val) begin
            head_mem[init_ptr_wr_req_flowid] <= init_ptr_wr_req_data;
            tail_mem[init_ptr_wr_req_flowid] <= init_ptr_wr_req_data;
         end
         if (tail_we)
            tail_mem[app_tail_ptr_tx_wr_req_flowid] <= app_tail_ptr_tx_wr_req_data;
         if (head_we)
            head_mem[eng_head_ptr_wr_req_flowid] <= eng_head_ptr_wr_req_data;
         if (tail_acc && tail_ovf)
            tail_ovf_err <= 1'b1;
      end
   end

   // Init and the other writers are mutually exclusive, so init simply wins the mux
   assign t_init_hit = init_ptr_wr_req_val
                    && init_ptr_wr_req_flowid == app_tail_ptr_tx_rd_req_flowid;
   assign t_byp_val  = t_init_hit || (tail_we
                    && app_tail_ptr_tx_wr_req_flowid == app_tail_ptr_tx_rd_req_flowid);
   assign t_byp_data = t_init_hit ? init_ptr_wr_req_data
                                  : app_tail_ptr_tx_wr_req_data;

   assign h_init_hit = init_ptr_wr_req_val
                    && init_ptr_wr_req_flowid == app_head_ptr_tx_rd_req_flowid;
   assign h_byp_val  = h_init_hit || (head_we
                    && eng_head_ptr_wr_req_flowid == app_head_ptr_tx_rd_req_flowid);
   assign h_byp_data = h_init_hit ? init_ptr_wr_req_data
                                  : eng_head_ptr_wr_req_data;

   tcp_tx_ptr_rd_port #(.FLOW_ID_W(FLOW_ID_W), .PTR_W(PTR_W)) u_tail_rd (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_val     (app_tail_ptr_tx_rd_req_val),
      .req_flowid  (app_tail_ptr_tx_rd_req_flowid),
      .req_rdy     (tail_ptr_app_tx_rd_req_rdy),
      .byp_val     (t_byp_val),
      .byp_data    (t_byp_data),
      .mem_data    (tail_mem[app_tail_ptr_tx_rd_req_flowid]),
      .resp_val    (tail_ptr_app_tx_rd_resp_val),
      .resp_flowid (tail_ptr_app_tx_rd_resp_flowid),
      .resp_data   (tail_ptr_app_tx_rd_resp_data),
      .resp_rdy    (app_tail_ptr_tx_rd_resp_rdy)
   );

   tcp_tx_ptr_rd_port #(.FLOW_ID_W(FLOW_ID_W), .PTR_W(PTR_W)) u_head_rd (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_val     (app_head_ptr_tx_rd_req_val),
      .req_flowid  (app_head_ptr_tx_rd_req_flowid),
      .req_rdy     (head_ptr_app_tx_rd_req_rdy),
      .byp_val     (h_byp_val),
      .byp_data    (h_byp_data),
      .mem_data    (head_mem[app_head_ptr_tx_rd_req_flowid]),
      .resp_val    (head_ptr_app_tx_rd_resp_val),
      .resp_flowid (head_ptr_app_tx_rd_resp_flowid),
      .resp_data   (head_ptr_app_tx_rd_resp_data),
      .resp_rdy    (app_head_ptr_tx_rd_resp_rdy)
   );

endmodule

// File: tb/tb_tcp_tx_ptr_store.sv
// Scoreboard bench for tcp_tx_ptr_store: directed vectors, queued expectations.
module tb_tcp_tx_ptr_store;
   import tcp_tx_ptr_pkg::*;

   localparam int FW = DEF_FLOW_ID_W;
   localparam int PW = DEF_PTR_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tw_val = 1'b0;
   logic [FW-1:0] tw_flow = '0;
   logic [PW:0]   tw_data = '0;
   logic          tw_rdy;
   logic          tr_val = 1'b0;
   logic [FW-1:0] tr_flow = '0;
   logic          tr_rdy;
   logic          trs_val;
   logic [FW-1:0] trs_flow;
   logic [PW:0]   trs_data;
   logic          trs_rdy = 1'b1;
   logic          hr_val = 1'b0;
   logic [FW-1:0] hr_flow = '0;
   logic          hr_rdy;
   logic          hrs_val;
   logic [FW-1:0] hrs_flow;
   logic [PW:0]   hrs_data;
   logic          hrs_rdy = 1'b1;
   logic          ew_val = 1'b0;
   logic [FW-1:0] ew_flow = '0;
   logic [PW:0]   ew_data = '0;
   logic          ew_rdy;
   logic          in_val = 1'b0;
   logic [FW-1:0] in_flow = '0;
   logic [PW:0]   in_data = '0;
   logic          ovf;

   int n_tests = 0;
   int n_fail  = 0;

   ptr_rd_resp_t tq[$];
   ptr_rd_resp_t hq[$];

   always #5 clk = ~clk;

   tcp_tx_ptr_store dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .app_tail_ptr_tx_wr_req_val     (tw_val),
      .app_tail_ptr_tx_wr_req_flowid  (tw_flow),
      .app_tail_ptr_tx_wr_req_data    (tw_data),
      .tail_ptr_app_tx_wr_req_rdy     (tw_rdy),
      .app_tail_ptr_tx_rd_req_val     (tr_val),
      .app_tail_ptr_tx_rd_req_flowid  (tr_flow),
      .tail_ptr_app_tx_rd_req_rdy     (tr_rdy),
      .tail_ptr_app_tx_rd_resp_val    (trs_val),
      .tail_ptr_app_tx_rd_resp_flowid (trs_flow),
      .tail_ptr_app_tx_rd_resp_data   (trs_data),
      .app_tail_ptr_tx_rd_resp_rdy    (trs_rdy),
      .app_head_ptr_tx_rd_req_val     (hr_val),
      .app_head_ptr_tx_rd_req_flowid  (hr_flow),
      .head_ptr_app_tx_rd_req_rdy     (hr_rdy),
      .head_ptr_app_tx_rd_resp_val    (hrs_val),
      .head_ptr_app_tx_rd_resp_flowid (hrs_flow),
      .head_ptr_app_tx_rd_resp_data   (hrs_data),
      .app_head_ptr_tx_rd_resp_rdy    (hrs_rdy),
      .eng_head_ptr_wr_req_val        (ew_val),
      .eng_head_ptr_wr_req_flowid     (ew_flow),
      .eng_head_ptr_wr_req_data       (ew_data),
      .head_ptr_eng_wr_req_rdy        (ew_rdy),
      .init_ptr_wr_req_val            (in_val),
      .init_ptr_wr_req_flowid         (in_flow),
      .init_ptr_wr_req_data           (in_data),
      .tail_ovf_err                   (ovf)
   );

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ptr_rd_resp_t mk(int f, int d);
      ptr_rd_resp_t r;
      r.flowid = f[FW-1:0];
      r.data   = d[PW:0];
      return r;
   endfunction

   // Monitor: a response handshakes at the next posedge when val && rdy here
   always @(negedge clk) begin
      if (rst_n) begin
         if (trs_val && trs_rdy) begin
            if (tq.size() == 0) check("tail_unexpected", 32'd1, 32'd0);
            else check("tail_resp", {14'd0, trs_flow, trs_data},
                       {14'd0, tq.pop_front()});
         end
         if (hrs_val && hrs_rdy) begin
            if (hq.size() == 0) check("head_unexpected", 32'd1, 32'd0);
            else check("head_resp", {14'd0, hrs_flow, hrs_data},
                       {14'd0, hq.pop_front()});
         end
      end
   end

   initial begin
      #12;
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_tval", {31'd0, trs_val}, 32'd0);
      check("rst_hval", {31'd0, hrs_val}, 32'd0);
      check("rst_tdata", {17'd0, trs_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // reset contents and 1-cycle latency
      tr_val = 1; tr_flow = 2; tq.push_back(mk(2, 0));
      hr_val = 1; hr_flow = 2; hq.push_back(mk(2, 0));
      tick();
      tr_val = 0; hr_val = 0;
      check("lat_tval", {31'd0, trs_val}, 32'd1);
      check("lat_hval", {31'd0, hrs_val}, 32'd1);

      // init flow 5, then read both pointers
      in_val = 1; in_flow = 5; in_data = 15'h100;
      tick();
      in_val = 0;
      tr_val = 1; tr_flow = 5; tq.push_back(mk(5, 'h100));
      hr_val = 1; hr_flow = 5; hq.push_back(mk(5, 'h100));
      tick();
      tr_val = 0; hr_val = 0;

      // init bypass on both arrays
      in_val = 1; in_flow = 3; in_data = 15'h55;
      tr_val = 1; tr_flow = 3; tq.push_back(mk(3, 'h55));
      hr_val = 1; hr_flow = 3; hq.push_back(mk(3, 'h55));
      tick();
      in_val = 0; tr_val = 0; hr_val = 0;

      // occupancy exactly 2**PTR_W is allowed
      tw_val = 1; tw_flow = 3; tw_data = 15'h4055;
      tick();
      tw_val = 0;
      check("ovf_boundary", {31'd0, ovf}, 32'd0);
      tr_val = 1; tr_flow = 3; tq.push_back(mk(3, 'h4055));
      tick();
      tr_val = 0;

      // wrapped occupancy: 0x0100 - 0x7F00 = 0x0200
      in_val = 1; in_flow = 6; in_data = 15'h7F00;
      tick();
      in_val = 0;
      tw_val = 1; tw_flow = 6; tw_data = 15'h0100;
      tick();
      tw_val = 0;
      check("ovf_wrap", {31'd0, ovf}, 32'd0);
      tr_val = 1; tr_flow = 6; tq.push_back(mk(6, 'h0100));
      tick();
      tr_val = 0;

      // tail write bypass into same-cycle read
      tw_val = 1; tw_flow = 5; tw_data = 15'h2100;
      tr_val = 1; tr_flow = 5; tq.push_back(mk(5, 'h2100));
      tick();
      tw_val = 0; tr_val = 0;

      // overflowing write: dropped, not bypassed, error set
      tw_val = 1; tw_flow = 5; tw_data = 15'h4101;
      check("ovf_wr_rdy", {31'd0, tw_rdy}, 32'd1);
      tr_val = 1; tr_flow = 5; tq.push_back(mk(5, 'h2100));
      tick();
      tw_val = 0; tr_val = 0;
      check("ovf_set", {31'd0, ovf}, 32'd1);
      tr_val = 1; tr_flow = 5; tq.push_back(mk(5, 'h2100));
      tick();
      tr_val = 0;

      // head advance bypass into same-cycle read
      ew_val = 1; ew_flow = 2; ew_data = 15'h123;
      hr_val = 1; hr_flow = 2; hq.push_back(mk(2, 'h123));
      tick();
      ew_val = 0; hr_val = 0;
      tick();

      // backpressure: response held stable across a head advance
      hrs_rdy = 0;
      hr_val = 1; hr_flow = 5; hq.push_back(mk(5, 'h100));
      tick();
      hr_val = 0;
      check("hold_req_rdy", {31'd0, hr_rdy}, 32'd0);
      ew_val = 1; ew_flow = 5; ew_data = 15'h200;
      tick();
      ew_val = 0;
      check("hold_val", {31'd0, hrs_val}, 32'd1);
      check("hold_data", {17'd0, hrs_data}, 32'h100);
      check("hold_flow", {29'd0, hrs_flow}, 32'd5);

      // release and stream one read per cycle
      hrs_rdy = 1;
      hr_val = 1; hr_flow = 5; hq.push_back(mk(5, 'h200));
      tick();
      check("b2b_rdy0", {31'd0, hr_rdy}, 32'd1);
      hr_flow = 2; hq.push_back(mk(2, 'h123));
      tick();
      check("b2b_rdy1", {31'd0, hr_rdy}, 32'd1);
      hr_flow = 1; hq.push_back(mk(1, 0));
      tick();
      hr_val = 0;
      check("b2b_val", {31'd0, hrs_val}, 32'd1);
      check("b2b_last", {17'd0, hrs_data}, 32'd0);

      // init blocks the engine and tail writers for one cycle
      in_val = 1; in_flow = 1; in_data = 15'h10;
      ew_val = 1; ew_flow = 1; ew_data = 15'h30;
      tw_val = 1; tw_flow = 1; tw_data = 15'h20;
      #1;
      check("init_eng_rdy", {31'd0, ew_rdy}, 32'd0);
      check("init_tw_rdy", {31'd0, tw_rdy}, 32'd0);
      tick();
      in_val = 0;
      #1;
      check("post_eng_rdy", {31'd0, ew_rdy}, 32'd1);
      tick();
      ew_val = 0; tw_val = 0;
      hr_val = 1; hr_flow = 1; hq.push_back(mk(1, 'h30));
      tr_val = 1; tr_flow = 1; tq.push_back(mk(1, 'h20));
      tick();
      hr_val = 0; tr_val = 0;

      check("ovf_sticky", {31'd0, ovf}, 32'd1);

      for (int i = 0; i < 20; i++) begin
         if (tq.size() == 0 && hq.size() == 0) break;
         tick();
      end
      check("tq_drained", tq.size(), 32'd0);
      check("hq_drained", hq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
